// File: rtl/nprime0_calc_pkg.sv
// Shared word width and FSM encoding for the n'0 (negated inverse of n0) generator.
package nprime0_calc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int IDX_WIDTH  = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ITER  = 3'd1,
    S_NEG   = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/nprime0_calc_if.sv
// Request/completion handshake plus the write port of the one-word n'0 memory.
interface nprime0_calc_if;
  import nprime0_calc_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] n0;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] nprime;
  logic                  mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;

  modport master (
    output start, n0,
    input  busy, done, err, nprime, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  start, n0,
    output busy, done, err, nprime, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/nprime0_calc.sv
// Bit-serial computation of n'0 = -(n0^-1) mod 2^DATA_WIDTH, written once into the n'0 memory.
module nprime0_calc
  import nprime0_calc_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  nprime0_calc_if.slave  bus
);

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] n0_q, n0_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [DATA_WIDTH-1:0] t_q, t_d;
  logic [IDX_WIDTH-1:0]  i_q, i_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] nprime_q, nprime_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_wren_q, mem_wren_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latch).
    state_d    = state_q;
    n0_d       = n0_q;
    y_d        = y_q;
    t_d        = t_q;
    i_d        = i_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    nprime_d   = nprime_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.n0[0]) begin
            n0_d    = bus.n0;
            y_d     = ONE;
            t_d     = bus.n0;
            i_d     = IDX_WIDTH'(1);
            err_d   = 1'b0;
            state_d = S_ITER;
          end else begin
            // Even n0 has no inverse: report straight away, skip the write.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_ITER: begin
        // t tracks n0*y; clearing bit i of (t - 1) fixes bit i of y.
        if (t_q[i_q]) begin
          y_d[i_q] = 1'b1;
          t_d      = t_q + (n0_q << i_q);
        end
        i_d = i_q + IDX_WIDTH'(1);
        if (i_q == LAST_IDX) state_d = S_NEG;
      end

      S_NEG: begin
        nprime_d   = (~y_q) + ONE;
        mem_data_d = (~y_q) + ONE;
        mem_wren_d = 1'b1;
        state_d    = S_WRITE;
      end

      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_FIN;
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      n0_q       <= '0;
      y_q        <= '0;
      t_q        <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nprime_q   <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n0_q       <= n0_d;
      y_q        <= y_d;
      t_q        <= t_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nprime_q   <= nprime_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.nprime      = nprime_q;
  assign bus.mem_address = 1'b0;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_nprime0_calc.sv
// Directed and random-odd checks of nprime0_calc: values, latency, single write, err, abort by reset.
module tb_nprime0_calc;

  localparam int MAX_K = 60;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  nprime0_calc_if bus ();

  nprime0_calc dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse start with n, then observe each cycle k after the start edge until busy falls.
  task automatic run_op(input logic [31:0] n, input bit repulse,
                        output int done_k, output int wren_k, output int wren_cnt,
                        output logic [31:0] wdata, output int idle_k,
                        output logic err_at_done, output logic addr_bad);
    done_k = -1; wren_k = -1; idle_k = -1; wren_cnt = 0;
    wdata = '0; err_at_done = 1'b0; addr_bad = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.n0    = n;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.n0    = ~n;
    for (int k = 0; k < MAX_K; k++) begin
      @(negedge clock);
      if (bus.mem_wren) begin
        wren_cnt++;
        wren_k = k;
        wdata  = bus.mem_data;
        if (bus.mem_address !== 1'b0) addr_bad = 1'b1;
      end
      if (bus.done) begin
        done_k      = (done_k < 0) ? k : -2;
        err_at_done = bus.err;
      end
      if (!bus.busy) begin
        idle_k = k;
        break;
      end
      if (repulse && (k == 5 || k == 20)) begin
        bus.start = 1'b1;
        bus.n0    = 32'h0000_0005;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_odd(input logic [31:0] n, input logic [31:0] exp, input bit repulse);
    int done_k, wren_k, wren_cnt, idle_k;
    logic [31:0] wdata;
    logic err_at_done, addr_bad;
    run_op(n, repulse, done_k, wren_k, wren_cnt, wdata, idle_k, err_at_done, addr_bad);
    n_cmp++; if (wdata !== exp) begin n_bad++; $display("FAIL mem_data n0=%h: got %h expected %h", n, wdata, exp); end
    n_cmp++; if (bus.nprime !== exp) begin n_bad++; $display("FAIL nprime n0=%h: got %h expected %h", n, bus.nprime, exp); end
    n_cmp++; if (wren_cnt !== 1) begin n_bad++; $display("FAIL wren_count n0=%h: got %0d expected 1", n, wren_cnt); end
    n_cmp++; if (addr_bad !== 1'b0) begin n_bad++; $display("FAIL mem_address n0=%h: got nonzero expected 0", n); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL err n0=%h: got %b expected 0", n, err_at_done); end
    n_cmp++; if (wren_k !== 32) begin n_bad++; $display("FAIL wren_latency n0=%h: got %0d expected 32", n, wren_k); end
    n_cmp++; if (done_k !== 33) begin n_bad++; $display("FAIL done_latency n0=%h: got %0d expected 33", n, done_k); end
    n_cmp++; if (idle_k !== 34) begin n_bad++; $display("FAIL busy_fall n0=%h: got %0d expected 34", n, idle_k); end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.n0    = '0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.err, bus.mem_wren, bus.mem_address} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                        {bus.busy, bus.done, bus.err, bus.mem_wren, bus.mem_address});
    end
    n_cmp++; if (bus.nprime !== 32'h0) begin n_bad++; $display("FAIL reset_nprime: got %h expected 0", bus.nprime); end
    n_cmp++; if (bus.mem_data !== 32'h0) begin n_bad++; $display("FAIL reset_mem_data: got %h expected 0", bus.mem_data); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_vectors();
    test_odd(32'h0000_0003, 32'h5555_5555, 1'b0);
    test_odd(32'h0000_0005, 32'h3333_3333, 1'b0);
    test_odd(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    test_odd(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_even();
    int done_k, wren_k, wren_cnt, idle_k;
    logic [31:0] wdata;
    logic err_at_done, addr_bad;
    run_op(32'h0000_0010, 1'b0, done_k, wren_k, wren_cnt, wdata, idle_k, err_at_done, addr_bad);
    n_cmp++; if (done_k !== 0) begin n_bad++; $display("FAIL even_done_latency: got %0d expected 0", done_k); end
    n_cmp++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL even_err: got %b expected 1", err_at_done); end
    n_cmp++; if (wren_cnt !== 0) begin n_bad++; $display("FAIL even_wren_count: got %0d expected 0", wren_cnt); end
    n_cmp++; if (idle_k !== 1) begin n_bad++; $display("FAIL even_busy_fall: got %0d expected 1", idle_k); end
    n_cmp++; if (bus.nprime !== 32'h0000_0001) begin n_bad++; $display("FAIL even_nprime_kept: got %h expected 00000001", bus.nprime); end
    repeat (2) @(negedge clock);
    n_cmp++; if ({bus.err, bus.done} !== 2'b10) begin n_bad++; $display("FAIL err_hold: got err,done=%b expected 10", {bus.err, bus.done}); end
  endtask

  task automatic test_back_to_back();
    // Extra starts during a run must not queue a second operation.
    test_odd(32'h0000_0003, 32'h5555_5555, 1'b1);
    repeat (3) @(negedge clock);
    n_cmp++; if ({bus.busy, bus.done, bus.mem_wren} !== 3'b000) begin
      n_bad++; $display("FAIL no_queued_run: got busy,done,wren=%b expected 000", {bus.busy, bus.done, bus.mem_wren});
    end
  endtask

  task automatic test_reset_mid();
    int wren_seen;
    wren_seen = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.n0    = 32'h0000_0003;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (11) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.err, bus.mem_wren} !== 4'b0) begin
      n_bad++; $display("FAIL abort_flags: got %b expected 0000", {bus.busy, bus.done, bus.err, bus.mem_wren});
    end
    n_cmp++; if (bus.nprime !== 32'h0) begin n_bad++; $display("FAIL abort_nprime: got %h expected 0", bus.nprime); end
    n_cmp++; if (bus.mem_data !== 32'h0) begin n_bad++; $display("FAIL abort_mem_data: got %h expected 0", bus.mem_data); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.mem_wren || bus.busy) wren_seen++;
    end
    n_cmp++; if (wren_seen !== 0) begin n_bad++; $display("FAIL abort_no_resume: got %0d active cycles expected 0", wren_seen); end
    test_odd(32'h0000_0005, 32'h3333_3333, 1'b0);
  endtask

  task automatic test_random();
    int done_k, wren_k, wren_cnt, idle_k;
    logic [31:0] wdata, n, prod;
    logic err_at_done, addr_bad;
    for (int v = 0; v < 1000; v++) begin
      n = $urandom() | 32'h1;
      run_op(n, 1'b0, done_k, wren_k, wren_cnt, wdata, idle_k, err_at_done, addr_bad);
      prod = n * bus.nprime;
      n_cmp++; if (prod !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rand_product n0=%h: got %h expected ffffffff", n, prod); end
      n_cmp++; if (wren_cnt !== 1) begin n_bad++; $display("FAIL rand_wren_count n0=%h: got %0d expected 1", n, wren_cnt); end
      n_cmp++; if (wdata !== bus.nprime) begin n_bad++; $display("FAIL rand_mem_data n0=%h: got %h expected %h", n, wdata, bus.nprime); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_vectors();
    test_even();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nprime0_calc.md
Name: nprime0_calc

Overview:
- Upstream producer for the single-word n'0 constant ROM/RAM used by the Montgomery multiplier.
- Computes n'0 = -(n0^-1) mod 2^DATA_WIDTH from the least-significant modulus word n0, at runtime, using a bit-serial shift/add loop with no multiplier.
- Writes the result into the one-word nprime0 memory through its address/data/wren port, then signals completion to the ModExp controller.

Parameters:
- DATA_WIDTH, 32 (project-wide `DATA_WIDTH): word width of n0, n'0 and the memory data port.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- n0  input  DATA_WIDTH  least-significant modulus word; sampled on the accepted start edge.
- busy  output  1  high from accepted start until the return to IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  high with done when n0 was even; held until the next accepted start.
- nprime  output  DATA_WIDTH  registered result; valid from done until the next accepted start.
- mem_address  output  1  nprime0 memory address; constant 0.
- mem_data  output  DATA_WIDTH  nprime0 memory write data.
- mem_wren  output  1  nprime0 memory write enable; one-cycle pulse.

Behaviour:
- Reset (asynchronous, reset_n=0) applies these values immediately:
  - state IDLE;
  - busy, done, err, mem_wren all 0;
  - nprime and mem_data 0; mem_address 0;
  - internal y, t and i cleared.
- Reset mid-operation aborts the computation with no memory write. After reset deasserts the block waits for a new start.
- Internal registers:
  - y: DATA_WIDTH bits, inverse accumulator;
  - t: DATA_WIDTH bits, running value of n0*y mod 2^DATA_WIDTH;
  - i: $clog2(DATA_WIDTH) bits, bit index.
- IDLE:
  - On start=1 with n0[0]=1: y<=1, t<=n0, i<=1, err<=0, busy<=1, go to ITER.
  - On start=1 with n0[0]=0: err<=1, busy<=1, go to FIN. No memory write.
  - On start=0: stay in IDLE.
- ITER, one bit per cycle:
  - If t[i]=1: y[i]<=1 and t<=t+(n0<<i), truncated to DATA_WIDTH bits.
  - i<=i+1.
  - When i=DATA_WIDTH-1 the update is applied and the state moves to NEG. ITER therefore lasts exactly DATA_WIDTH-1 cycles.
- NEG: nprime <= (~y)+1, modulo 2^DATA_WIDTH (two's-complement negate); go to WRITE.
- WRITE: mem_wren=1, mem_data=nprime, mem_address=0 for exactly one cycle; go to FIN.
- FIN: done=1 for one cycle, busy stays 1; go to IDLE, where busy<=0.
- Latency for odd n0, counted from the edge that samples start:
  - mem_wren is high in the cycle after edge DATA_WIDTH;
  - done is high in the cycle after edge DATA_WIDTH+1;
  - total DATA_WIDTH+2 cycles before busy falls (34 for DATA_WIDTH=32).
- Latency for even n0: done and err are high in the cycle after the start edge.
- start while busy=1 is ignored; there is no queueing.
- start and done may not coincide, because done only occurs when busy=1.
- n0 may change after the start edge without affecting the result (n0 is captured at start).
- Invariant at ITER exit: (n0*y) mod 2^DATA_WIDTH = 1.
- The memory's registered read output is not consumed here; the downstream multiplier reads the memory only after done.

Decomposition:
- Shared package/include (_parameter.v):
  - DATA_WIDTH;
  - state encoding constants S_IDLE, S_ITER, S_NEG, S_WRITE, S_FIN (3-bit).
- No sub-module. The shift/add update is a single always block; splitting it out gives no reuse.

Test Plan:
- n0=0x00000003, start pulse -> single mem_wren with mem_data=0x55555555, mem_address=0; done with err=0; nprime=0x55555555; done exactly 33 cycles after the start edge.
- n0=0x00000005 -> nprime=0x33333333. n0=0x00000001 -> nprime=0xFFFFFFFF. n0=0xFFFFFFFF -> nprime=0x00000001. Each gives exactly one write.
- n0=0x00000010 (even) -> done and err high in the cycle after start; mem_wren never asserted; nprime unchanged.
- start re-pulsed at cycles 5 and 20 of a run with n0=3 -> ignored; a single done; result still 0x55555555.
- reset_n dropped at ITER cycle 10 -> all outputs 0 immediately; no mem_wren. A new start with n0=5 then completes normally with 0x33333333.
- Random odd n0 (1000 vectors) -> scoreboard checks (n0*nprime) mod 2^32 = 0xFFFFFFFF and exactly one mem_wren per run.
